// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, dual-port instruction memory (fetch + program load)
// and a small decoupling FIFO toward decode with valid/ready handshake and redirect flush.
module fetch_unit #(
  parameter int               cXLEN      = 32,
  parameter int               cImemDepth = 1024,
  parameter int               cFifoDepth = 4,
  parameter logic [cXLEN-1:0] cResetPc   = '0
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iRedirect,
  input  logic [cXLEN-1:0]              iRedirectPc,
  input  logic                          iWEn,
  input  logic [$clog2(cImemDepth)-1:0] iWAddr,
  input  logic [cXLEN-1:0]              iWData,
  output logic                          oValid,
  output logic [cXLEN-1:0]              oInstr,
  output logic [cXLEN-1:0]              oPc,
  input  logic                          iReady,
  output logic [$clog2(cFifoDepth):0]   oFifoLevel
);

  localparam int cAW   = $clog2(cImemDepth);
  localparam int cFW   = $clog2(cFifoDepth);
  localparam int cCntW = cFW + 1;
  localparam int cOccW = cCntW + 1;

  logic [cXLEN-1:0] memQ [cImemDepth];
  logic [cXLEN-1:0] rdataQ;

  logic [cXLEN-1:0] fifoInstrQ [cFifoDepth];
  logic [cXLEN-1:0] fifoPcQ    [cFifoDepth];

  logic [cXLEN-1:0] pcQ, pcD;
  logic             inFlightQ, inFlightD;
  logic [cXLEN-1:0] inFlightPcQ, inFlightPcD;
  logic [cFW-1:0]   rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
  logic [cCntW-1:0] countQ, countD;

  logic             pop, push, issue;
  logic [cOccW-1:0] occupancy;

  // Credit check counts the word still in the memory pipeline so the FIFO can never overflow.
  always_comb begin
    pop       = oValid && iReady;
    push      = inFlightQ && !iRedirect;
    occupancy = cOccW'(countQ) + cOccW'(inFlightQ) - cOccW'(pop);
    issue     = !iRst && !iRedirect && (occupancy < cOccW'(cFifoDepth));
  end

  always_comb begin
    pcD         = pcQ;
    inFlightD   = 1'b0;
    inFlightPcD = inFlightPcQ;
    rdPtrD      = rdPtrQ;
    wrPtrD      = wrPtrQ;
    countD      = countQ;
    if (iRedirect) begin
      pcD    = {iRedirectPc[cXLEN-1:2], 2'b00};
      rdPtrD = '0;
      wrPtrD = '0;
      countD = '0;
    end else begin
      if (issue) begin
        pcD         = pcQ + cXLEN'(4);
        inFlightD   = 1'b1;
        inFlightPcD = pcQ;
      end
      if (push) wrPtrD = wrPtrQ + cFW'(1);
      if (pop)  rdPtrD = rdPtrQ + cFW'(1);
      countD = countQ + cCntW'(push) - cCntW'(pop);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      pcQ         <= cResetPc;
      inFlightQ   <= 1'b0;
      inFlightPcQ <= '0;
      rdPtrQ      <= '0;
      wrPtrQ      <= '0;
      countQ      <= '0;
    end else begin
      pcQ         <= pcD;
      inFlightQ   <= inFlightD;
      inFlightPcQ <= inFlightPcD;
      rdPtrQ      <= rdPtrD;
      wrPtrQ      <= wrPtrD;
      countQ      <= countD;
    end
  end

  // Storage is not reset; a read and write to the same word in one cycle returns the old word.
  always_ff @(posedge iClk) begin
    if (iWEn) memQ[iWAddr] <= iWData;
    if (issue) rdataQ <= memQ[pcQ[cAW+1:2]];
  end

  always_ff @(posedge iClk) begin
    if (push) begin
      fifoInstrQ[wrPtrQ] <= rdataQ;
      fifoPcQ[wrPtrQ]    <= inFlightPcQ;
    end
  end

  assign oValid     = (countQ != '0);
  assign oInstr     = oValid ? fifoInstrQ[rdPtrQ] : '0;
  assign oPc        = oValid ? fifoPcQ[rdPtrQ] : '0;
  assign oFifoLevel = countQ;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic, all compared
// cycle by cycle against a queue-based behavioural model of the fetch stage.
module tb_fetch_unit;

  localparam int          cXLEN      = 32;
  localparam int          cImemDepth = 1024;
  localparam int          cFifoDepth = 4;
  localparam logic [31:0] cResetPc   = 32'h0;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iRedirect;
  logic [31:0] iRedirectPc;
  logic        iWEn;
  logic [9:0]  iWAddr;
  logic [31:0] iWData;
  logic        oValid;
  logic [31:0] oInstr;
  logic [31:0] oPc;
  logic        iReady;
  logic [2:0]  oFifoLevel;

  fetch_unit #(
    .cXLEN(cXLEN), .cImemDepth(cImemDepth), .cFifoDepth(cFifoDepth), .cResetPc(cResetPc)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iRedirect(iRedirect), .iRedirectPc(iRedirectPc),
    .iWEn(iWEn), .iWAddr(iWAddr), .iWData(iWData), .oValid(oValid), .oInstr(oInstr),
    .oPc(oPc), .iReady(iReady), .oFifoLevel(oFifoLevel)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entryT;

  logic [31:0] modelMem [cImemDepth];
  entryT       modelFifo [$];
  logic [31:0] modelPc;
  logic [31:0] modelInFlightPc;
  logic [31:0] modelInFlightData;
  bit          modelInFlight;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  task automatic modelReset();
    modelFifo.delete();
    modelPc       = cResetPc;
    modelInFlight = 0;
  endtask

  // Behavioural view of one clock edge: decode takes the head, the outstanding word lands,
  // and a new fetch starts whenever the FIFO still has room for it.
  task automatic modelEdge();
    bit    popNow;
    bit    fetchNow;
    int    occ;
    entryT e;
    popNow   = (modelFifo.size() > 0) && iReady;
    occ      = modelFifo.size() + int'(modelInFlight) - int'(popNow);
    fetchNow = !iRedirect && (occ < cFifoDepth);
    if (iRedirect) begin
      modelFifo.delete();
      modelInFlight = 0;
      modelPc       = iRedirectPc & ~32'h3;
    end else begin
      if (popNow) void'(modelFifo.pop_front());
      if (modelInFlight) begin
        e.instr = modelInFlightData;
        e.pc    = modelInFlightPc;
        modelFifo.push_back(e);
      end
      modelInFlight = fetchNow;
      if (fetchNow) begin
        modelInFlightData = modelMem[int'((modelPc >> 2) % cImemDepth)];
        modelInFlightPc   = modelPc;
        modelPc           = modelPc + 32'd4;
      end
    end
    if (iWEn) modelMem[iWAddr] = iWData;
  endtask

  task automatic checkAll();
    entryT head;
    head = '0;
    if (modelFifo.size() > 0) head = modelFifo[0];
    checkOutput("valid", {31'b0, oValid}, {31'b0, modelFifo.size() > 0});
    checkOutput("instr", oInstr, head.instr);
    checkOutput("pc", oPc, head.pc);
    checkOutput("level", 32'(oFifoLevel), 32'(modelFifo.size()));
  endtask

  task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit wen,
                               input logic [9:0] waddr, input logic [31:0] wdata, input bit ready);
    iRedirect   = redir;
    iRedirectPc = rpc;
    iWEn        = wen;
    iWAddr      = waddr;
    iWData      = wdata;
    iReady      = ready;
    @(posedge iClk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic pulseReset();
    iRst      = 1'b1;
    iRedirect = 1'b0;
    iWEn      = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    checkAll();
  endtask

  task automatic stepN(input int n, input bit ready);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 1'b0, 10'h0, 32'h0, ready);
  endtask

  initial begin
    iRst = 1'b1; iRedirect = 1'b0; iRedirectPc = '0; iWEn = 1'b0;
    iWAddr = '0; iWData = '0; iReady = 1'b1;
    modelReset();
    #2;
    checkAll();

    // Hold a redirect while loading the whole memory so no fetch sees uninitialised words.
    iRedirect = 1'b1;
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    for (int i = 0; i < cImemDepth; i++)
      applyStimulus(1'b1, 32'h0, 1'b1, 10'(i), (i < 8) ? 32'h13 + 32'(i) : $urandom, 1'b1);

    // Streaming from reset
    pulseReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 10'h0, 32'h0, 1'b1);
    checkOutput("noValidCycle1", {31'b0, oValid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 10'h0, 32'h0, 1'b1);
    checkOutput("firstPc", oPc, 32'h0);
    checkOutput("firstInstr", oInstr, 32'h13);
    applyStimulus(1'b0, 32'h0, 1'b0, 10'h0, 32'h0, 1'b1);
    checkOutput("secondPc", oPc, 32'h4);
    checkOutput("secondInstr", oInstr, 32'h14);
    stepN(8, 1'b1);

    // Backpressure
    pulseReset();
    stepN(2, 1'b1);
    stepN(10, 1'b0);
    checkOutput("bpLevel", 32'(oFifoLevel), 32'd4);
    checkOutput("bpHeadPc", oPc, 32'h0);
    checkOutput("bpHeadInstr", oInstr, 32'h13);
    stepN(12, 1'b1);

    // Redirect flush with three entries queued
    pulseReset();
    for (int i = 0; i < 10 && modelFifo.size() != 3; i++) stepN(1, 1'b0);
    checkOutput("preFlushLevel", 32'(oFifoLevel), 32'd3);
    applyStimulus(1'b1, 32'h20, 1'b0, 10'h0, 32'h0, 1'b0);
    checkOutput("flushValid", {31'b0, oValid}, 32'd0);
    checkOutput("flushLevel", 32'(oFifoLevel), 32'd0);
    stepN(2, 1'b1);
    checkOutput("flushTargetPc", oPc, 32'h20);
    checkOutput("flushTargetInstr", oInstr, modelMem[8]);
    stepN(4, 1'b1);

    // Misaligned target and wrap past the memory depth
    applyStimulus(1'b1, 32'h23, 1'b0, 10'h0, 32'h0, 1'b1);
    stepN(2, 1'b1);
    checkOutput("alignedPc", oPc, 32'h20);
    applyStimulus(1'b1, 32'hFFC, 1'b0, 10'h0, 32'h0, 1'b1);
    stepN(2, 1'b1);
    checkOutput("wrapFirstPc", oPc, 32'hFFC);
    stepN(1, 1'b1);
    checkOutput("wrapNextPc", oPc, 32'h1000);
    checkOutput("wrapNextInstr", oInstr, modelMem[0]);

    // Write to the word being fetched in the same cycle
    applyStimulus(1'b1, 32'h10, 1'b0, 10'h0, 32'h0, 1'b1);
    stepN(1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 10'd5, 32'hDEADBEEF, 1'b1);
    stepN(1, 1'b1);
    checkOutput("collisionOldPc", oPc, 32'h14);
    checkOutput("collisionOldInstr", oInstr, 32'h18);
    applyStimulus(1'b1, 32'h14, 1'b0, 10'h0, 32'h0, 1'b1);
    stepN(2, 1'b1);
    checkOutput("collisionNewInstr", oInstr, 32'hDEADBEEF);

    // Randomized traffic with redirects, program writes and mid-stream resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulseReset();
      end else begin
        applyStimulus($urandom_range(0, 15) == 0,
                      ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom,
                      $urandom_range(0, 3) == 0, 10'($urandom_range(0, 63)), $urandom,
                      1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
